tod_receiver_holdover: RTL and testbench

//   Parametrised successor time-of-day receiver for the embedded event receiver (evr_axi).

---
 rtl/tod_receiver_holdover.sv | 204 ++++++++++++++++++++
 tb/tb_tod_receiver_holdover.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tod_receiver_holdover.sv
// Time-of-day receiver: assembles serial seconds frames between seconds markers,
// qualifies lock over consecutive in-sequence frames and flywheels through bad frames.
module tod_receiver_holdover #(
    parameter int EVCODE_WIDTH  = 8,
    parameter int SECONDS_WIDTH = 32,
    parameter int TICKS_WIDTH   = 32,
    parameter int COUNTER_WIDTH = 10,
    parameter logic [EVCODE_WIDTH-1:0] EVCODE_SHIFT_ZERO = 8'h70,
    parameter logic [EVCODE_WIDTH-1:0] EVCODE_SHIFT_ONE  = 8'h71,
    parameter logic [EVCODE_WIDTH-1:0] EVCODE_MARKER     = 8'h7D,
    parameter int LOCK_COUNT     = 2,
    parameter int HOLDOVER_LIMIT = 4
) (
    input  logic                                 Clock,
    input  logic                                 Reset_n,
    input  logic [EVCODE_WIDTH-1:0]              EventStream,
    input  logic                                 clearCounters,
    output logic [SECONDS_WIDTH+TICKS_WIDTH-1:0] TimeStamp,
    output logic                                 tsValid,
    output logic                                 holdover,
    output logic                                 ppsStrobe,
    output logic [TICKS_WIDTH-1:0]               ticksPerSecond,
    output logic [COUNTER_WIDTH-1:0]             tooFewCount,
    output logic [COUNTER_WIDTH-1:0]             tooManyCount,
    output logic [COUNTER_WIDTH-1:0]             outOfSeqCount
);

    localparam int BIT_CNT_W = $clog2(SECONDS_WIDTH + 2);
    localparam int MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W    = (HOLDOVER_LIMIT < 1) ? 1 : $clog2(HOLDOVER_LIMIT + 1);
    localparam logic [BIT_CNT_W-1:0] FULL_COUNT = BIT_CNT_W'(SECONDS_WIDTH);
    localparam logic [BIT_CNT_W-1:0] SAT_COUNT  = BIT_CNT_W'(SECONDS_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_HOLDOVER
    } state_t;

    state_t                     state, state_next;
    logic [SECONDS_WIDTH-1:0]   shift_reg;
    logic [SECONDS_WIDTH-1:0]   expect_seconds;
    logic [BIT_CNT_W-1:0]       bit_count;
    logic [MATCH_W-1:0]         match_count, match_next;
    logic [MISS_W-1:0]          miss_count, miss_next;
    logic [SECONDS_WIDTH-1:0]   ts_seconds, seconds_next;
    logic [TICKS_WIDTH-1:0]     ts_ticks;

    logic is_shift, is_marker, frame_good, frame_few, frame_many, good_match, tick_ovf;

    assign is_shift   = (EventStream == EVCODE_SHIFT_ZERO) || (EventStream == EVCODE_SHIFT_ONE);
    assign is_marker  = (EventStream == EVCODE_MARKER);
    assign frame_good = (bit_count == FULL_COUNT);
    assign frame_few  = (bit_count <  FULL_COUNT);
    assign frame_many = (bit_count >  FULL_COUNT);
    assign good_match = frame_good && (shift_reg == expect_seconds);
    assign tick_ovf   = ts_ticks[TICKS_WIDTH-1] && !is_marker;

    assign TimeStamp  = {ts_seconds, ts_ticks};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            shift_reg      <= '0;
            bit_count      <= '0;
            expect_seconds <= '0;
        end else if (is_shift) begin
            shift_reg <= {shift_reg[SECONDS_WIDTH-2:0], EventStream[0]};
            if (bit_count != SAT_COUNT)
                bit_count <= bit_count + 1'b1;
        end else if (is_marker) begin
            bit_count <= '0;
            if (frame_good)
                expect_seconds <= shift_reg + 1'b1;
        end
    end

    // The tick counter freezes once its top bit sets so a lost marker stream is detectable
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ts_ticks       <= '0;
            ticksPerSecond <= '0;
            ppsStrobe      <= 1'b0;
        end else begin
            ppsStrobe <= is_marker;
            if (is_marker) begin
                ts_ticks       <= '0;
                ticksPerSecond <= ts_ticks;
            end else if (!ts_ticks[TICKS_WIDTH-1]) begin
                ts_ticks <= ts_ticks + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_UNLOCKED;
            ts_seconds  <= '0;
            match_count <= '0;
            miss_count  <= '0;
            tsValid     <= 1'b0;
            holdover    <= 1'b0;
        end else begin
            state       <= state_next;
            ts_seconds  <= seconds_next;
            match_count <= match_next;
            miss_count  <= miss_next;
            tsValid     <= (state_next == ST_LOCKED) || (state_next == ST_HOLDOVER);
            holdover    <= (state_next == ST_HOLDOVER);
        end
    end

    always_comb begin
        state_next   = state;
        seconds_next = ts_seconds;
        match_next   = match_count;
        miss_next    = miss_count;
        if (tick_ovf) begin
            state_next = ST_UNLOCKED;
            match_next = '0;
            miss_next  = '0;
        end else if (is_marker) begin
            case (state)
                ST_UNLOCKED: begin
                    if (frame_good) begin
                        match_next = MATCH_W'(1);
                        if (LOCK_COUNT == 1) begin
                            state_next   = ST_LOCKED;
                            seconds_next = shift_reg;
                        end else begin
                            state_next = ST_ACQUIRE;
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (good_match) begin
                        if (int'(match_count) + 1 >= LOCK_COUNT) begin
                            state_next   = ST_LOCKED;
                            seconds_next = shift_reg;
                            match_next   = '0;
                        end else begin
                            match_next = match_count + 1'b1;
                        end
                    end else if (frame_good) begin
                        match_next = MATCH_W'(1);
                    end else begin
                        state_next = ST_UNLOCKED;
                        match_next = '0;
                    end
                end
                ST_LOCKED: begin
                    if (good_match) begin
                        seconds_next = shift_reg;
                    end else begin
                        seconds_next = ts_seconds + 1'b1;
                        if (HOLDOVER_LIMIT == 0) begin
                            state_next = ST_UNLOCKED;
                        end else begin
                            state_next = ST_HOLDOVER;
                            miss_next  = MISS_W'(1);
                        end
                    end
                end
                ST_HOLDOVER: begin
                    if (good_match) begin
                        state_next   = ST_LOCKED;
                        seconds_next = shift_reg;
                        miss_next    = '0;
                    end else if (int'(miss_count) + 1 >= HOLDOVER_LIMIT) begin
                        // Holdover exhausted: keep the last flywheeled second on display
                        state_next = ST_UNLOCKED;
                        miss_next  = '0;
                    end else begin
                        seconds_next = ts_seconds + 1'b1;
                        miss_next    = miss_count + 1'b1;
                    end
                end
                default: state_next = ST_UNLOCKED;
            endcase
        end
    end

    function automatic logic [COUNTER_WIDTH-1:0] bump(input logic [COUNTER_WIDTH-1:0] value,
                                                      input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && (value != '1))
            return value + 1'b1;
        return value;
    endfunction

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tooFewCount   <= '0;
            tooManyCount  <= '0;
            outOfSeqCount <= '0;
        end else begin
            tooFewCount   <= bump(tooFewCount,   is_marker && frame_few,  clearCounters);
            tooManyCount  <= bump(tooManyCount,  is_marker && frame_many, clearCounters);
            outOfSeqCount <= bump(outOfSeqCount, is_marker && frame_good && !good_match, clearCounters);
        end
    end

endmodule

// File: tb/tb_tod_receiver_holdover.sv
// Self-checking bench for tod_receiver_holdover: directed frame table, corner-case
// sequences, then random frames checked against a frame-level reference model.
module tb_tod_receiver_holdover;

    localparam int SW = 32;
    localparam int TW = 12;
    localparam int CW = 4;
    localparam logic [7:0] C_ZERO   = 8'h70;
    localparam logic [7:0] C_ONE    = 8'h71;
    localparam logic [7:0] C_MARKER = 8'h7D;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int HOLD_LIM = 4;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic [7:0]        EventStream;
    logic              clearCounters;
    logic [SW+TW-1:0]  TimeStamp;
    logic              tsValid, holdover, ppsStrobe;
    logic [TW-1:0]     ticksPerSecond;
    logic [CW-1:0]     tooFewCount, tooManyCount, outOfSeqCount;

    int total = 0;
    int bad   = 0;

    tod_receiver_holdover #(
        .SECONDS_WIDTH(SW),
        .TICKS_WIDTH  (TW),
        .COUNTER_WIDTH(CW)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .EventStream   (EventStream),
        .clearCounters (clearCounters),
        .TimeStamp     (TimeStamp),
        .tsValid       (tsValid),
        .holdover      (holdover),
        .ppsStrobe     (ppsStrobe),
        .ticksPerSecond(ticksPerSecond),
        .tooFewCount   (tooFewCount),
        .tooManyCount  (tooManyCount),
        .outOfSeqCount (outOfSeqCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          nbits;
        logic [31:0] value;
        int          span;
        bit          clr;
        logic [31:0] e_secs;
        bit          e_valid;
        bit          e_hold;
        int          e_few;
        int          e_many;
        int          e_oos;
    } vec_t;

    vec_t vecs[17];

    typedef enum {M_UNLOCKED, M_ACQUIRE, M_LOCKED, M_HOLDOVER} mode_t;
    mode_t       m_mode;
    logic [31:0] m_secs, m_expect;
    int          m_run, m_miss, m_few, m_many, m_oos;

    task automatic step(input logic [7:0] code, input logic clr);
        EventStream   = code;
        clearCounters = clr;
        @(posedge Clock);
        #1;
        EventStream   = 8'h00;
        clearCounters = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One frame: nbits shift codes (MSB first), idle fill, then the marker
    task automatic applyStimulus(input int nbits, input logic [63:0] value, input int span, input bit clr);
        for (int b = nbits - 1; b >= 0; b--)
            step(value[b] ? C_ONE : C_ZERO, 1'b0);
        for (int g = 0; g < span - nbits; g++)
            step(8'h00, 1'b0);
        step(C_MARKER, clr);
    endtask

    task automatic checkFrame(input string tag, input logic [31:0] secs, input bit valid, input bit hold,
                              input int span, input int few, input int many, input int oos);
        checkOutput({tag, " secs"},  TimeStamp[SW+TW-1:TW], secs);
        checkOutput({tag, " ticks"}, TimeStamp[TW-1:0], 0);
        checkOutput({tag, " valid"}, tsValid, valid);
        checkOutput({tag, " hold"},  holdover, hold);
        checkOutput({tag, " pps"},   ppsStrobe, 1);
        checkOutput({tag, " tps"},   ticksPerSecond, span);
        checkOutput({tag, " few"},   tooFewCount, few);
        checkOutput({tag, " many"},  tooManyCount, many);
        checkOutput({tag, " oos"},   outOfSeqCount, oos);
    endtask

    task automatic modelFrame(input int nbits, input logic [31:0] value, input bit clr);
        bit good, match;
        good  = (nbits == SW);
        match = good && (value == m_expect);
        if (nbits < SW && m_few < CNT_MAX)   m_few++;
        if (nbits > SW && m_many < CNT_MAX)  m_many++;
        if (good && !match && m_oos < CNT_MAX) m_oos++;
        if (good) m_expect = value + 32'd1;
        if (clr) begin
            m_few = 0; m_many = 0; m_oos = 0;
        end
        case (m_mode)
            M_UNLOCKED: if (good) begin m_mode = M_ACQUIRE; m_run = 1; end
            M_ACQUIRE: begin
                if (match) begin
                    m_run++;
                    if (m_run >= 2) begin m_mode = M_LOCKED; m_secs = value; end
                end else if (good) m_run = 1;
                else m_mode = M_UNLOCKED;
            end
            M_LOCKED: begin
                if (match) m_secs = value;
                else begin m_secs = m_secs + 32'd1; m_mode = M_HOLDOVER; m_miss = 1; end
            end
            M_HOLDOVER: begin
                if (match) begin m_mode = M_LOCKED; m_secs = value; end
                else if (m_miss + 1 >= HOLD_LIM) m_mode = M_UNLOCKED;
                else begin m_secs = m_secs + 32'd1; m_miss++; end
            end
        endcase
    endtask

    task automatic doReset();
        Reset_n = 1'b0;
        #1;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n       = 1'b0;
        EventStream   = 8'h00;
        clearCounters = 1'b0;

        vecs[0]  = '{32, 32'd5,          999, 0, 32'd0,   0, 0, 0, 0, 1};
        vecs[1]  = '{32, 32'd6,          999, 0, 32'd6,   1, 0, 0, 0, 1};
        vecs[2]  = '{32, 32'd7,          999, 0, 32'd7,   1, 0, 0, 0, 1};
        vecs[3]  = '{31, 32'h5A5A5A5A,   999, 0, 32'd8,   1, 1, 1, 0, 1};
        vecs[4]  = '{32, 32'd8,          999, 0, 32'd8,   1, 0, 1, 0, 1};
        vecs[5]  = '{33, 32'h12345678,   600, 0, 32'd9,   1, 1, 1, 1, 1};
        vecs[6]  = '{33, 32'h12345679,   600, 0, 32'd10,  1, 1, 1, 2, 1};
        vecs[7]  = '{33, 32'h1234567A,   600, 0, 32'd11,  1, 1, 1, 3, 1};
        vecs[8]  = '{33, 32'h1234567B,   600, 0, 32'd11,  0, 0, 1, 4, 1};
        vecs[9]  = '{33, 32'h1234567C,   600, 0, 32'd11,  0, 0, 1, 5, 1};
        vecs[10] = '{32, 32'd9,          400, 0, 32'd11,  0, 0, 1, 5, 1};
        vecs[11] = '{32, 32'd10,         400, 0, 32'd10,  1, 0, 1, 5, 1};
        vecs[12] = '{32, 32'd500,        400, 0, 32'd11,  1, 1, 1, 5, 2};
        vecs[13] = '{32, 32'd501,        400, 0, 32'd501, 1, 0, 1, 5, 2};
        vecs[14] = '{32, 32'hFFFFFFFF,   300, 0, 32'd502, 1, 1, 1, 5, 3};
        vecs[15] = '{32, 32'd0,          300, 0, 32'd0,   1, 0, 1, 5, 3};
        vecs[16] = '{30, 32'h3FFFFFFF,   300, 1, 32'd1,   1, 1, 0, 0, 0};

        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        checkOutput("reset timestamp", TimeStamp, 0);
        checkOutput("reset valid", tsValid, 0);
        checkOutput("reset hold", holdover, 0);
        checkOutput("reset pps", ppsStrobe, 0);
        checkOutput("reset tps", ticksPerSecond, 0);
        checkOutput("reset counters", {tooFewCount, tooManyCount, outOfSeqCount}, 0);
        Reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].nbits, {32'd0, vecs[i].value}, vecs[i].span, vecs[i].clr);
            checkFrame($sformatf("vec%0d", i), vecs[i].e_secs, vecs[i].e_valid, vecs[i].e_hold,
                       vecs[i].span, vecs[i].e_few, vecs[i].e_many, vecs[i].e_oos);
        end

        // Strobe lasts one cycle; ticks count idle cycles after the marker
        repeat (5) step(8'h00, 1'b0);
        checkOutput("pps drop", ppsStrobe, 0);
        checkOutput("tick count", TimeStamp[TW-1:0], 5);

        // Error counter saturation, then clear on an incrementing marker
        for (int i = 0; i < 20; i++)
            applyStimulus(3, 64'd5, 10, 1'b0);
        checkOutput("few saturate", tooFewCount, CNT_MAX);
        applyStimulus(3, 64'd5, 10, 1'b1);
        checkOutput("few clear wins", tooFewCount, 0);
        applyStimulus(3, 64'd5, 10, 1'b0);
        checkOutput("few after clear", tooFewCount, 1);

        // Lock again, then starve markers until the tick counter freezes
        applyStimulus(32, 64'd1, 100, 1'b0);
        applyStimulus(32, 64'd2, 100, 1'b0);
        checkOutput("relock valid", tsValid, 1);
        checkOutput("relock secs", TimeStamp[SW+TW-1:TW], 2);
        repeat (2100) step(8'h00, 1'b0);
        checkOutput("ovf ticks", TimeStamp[TW-1:0], 1 << (TW - 1));
        checkOutput("ovf valid", tsValid, 0);
        checkOutput("ovf hold", holdover, 0);
        step(C_MARKER, 1'b0);
        checkOutput("ovf marker tps", ticksPerSecond, 1 << (TW - 1));
        checkOutput("ovf marker ticks", TimeStamp[TW-1:0], 0);

        // Reset in the middle of a frame discards the partial bits
        for (int b = 0; b < 20; b++)
            step(C_ONE, 1'b0);
        Reset_n = 1'b0;
        #1;
        checkOutput("midreset timestamp", TimeStamp, 0);
        checkOutput("midreset counters", {tooFewCount, tooManyCount, outOfSeqCount}, 0);
        checkOutput("midreset valid", tsValid, 0);
        step(8'h00, 1'b0);
        Reset_n = 1'b1;
        applyStimulus(12, 64'hFFF, 50, 1'b0);
        checkFrame("postreset", 32'd0, 0, 0, 50, 1, 0, 0);

        // Random frames against the reference model
        doReset();
        m_mode = M_UNLOCKED; m_secs = '0; m_expect = '0;
        m_run = 0; m_miss = 0; m_few = 0; m_many = 0; m_oos = 0;
        for (int i = 0; i < 150; i++) begin
            int          kind, nbits, span;
            logic [31:0] value;
            bit          clr;
            kind  = $urandom_range(0, 99);
            value = $urandom;
            if (kind < 60) begin
                nbits = SW; value = m_expect;
            end else if (kind < 75) begin
                nbits = SW;
            end else if (kind < 88) begin
                nbits = $urandom_range(0, SW - 1);
            end else begin
                nbits = $urandom_range(SW + 1, SW + 8);
            end
            span = nbits + $urandom_range(3, 150);
            clr  = ($urandom_range(0, 19) == 0);
            applyStimulus(nbits, {32'd0, value}, span, clr);
            modelFrame(nbits, value, clr);
            checkFrame($sformatf("rand%0d", i), m_secs,
                       (m_mode == M_LOCKED) || (m_mode == M_HOLDOVER), m_mode == M_HOLDOVER,
                       span, m_few, m_many, m_oos);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
